// File: rtl/mdc_r2_stage.sv
// mdc_r2_stage -- one radix-2 multi-path delay commutator stage of a streaming
// FFT pipeline. Chain instances with DELAY = N/4, N/8, ..., 1.
//
// Datapath, in order: a lower-path input delay line (DELAY deep), a commutator
// driven by an internal modulo-2*DELAY counter, an upper-path delay line
// (DELAY deep), and a butterfly with either floor scaling or saturation. There
// is no twiddle multiply here.
//
// Parameters
//   WIDTH  signed width of every real/imag data port
//   DELAY  commutator distance in samples (power of two, >= 1)
//   SCALE  1: butterfly result >>> 1 (floor); 0: result saturated to WIDTH
//
// Ports
//   clk                    rising-edge clock
//   rst                    synchronous active-high reset
//   in_valid               input pair present this cycle
//   flush                  advance with zero data (drain)
//   bypass                 butterfly passes its inputs through unchanged
//   in_up_re / in_up_im    upper path input
//   in_lo_re / in_lo_im    lower path input
//   out_valid              output pair valid
//   out_up_re / out_up_im  butterfly sum output
//   out_lo_re / out_lo_im  butterfly difference output
//   ovf                    saturation occurred on this output sample
module mdc_r2_stage #(
  parameter int WIDTH = 9,
  parameter int DELAY = 1,
  parameter int SCALE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    flush,
  input  logic                    bypass,
  input  logic signed [WIDTH-1:0] in_up_re,
  input  logic signed [WIDTH-1:0] in_up_im,
  input  logic signed [WIDTH-1:0] in_lo_re,
  input  logic signed [WIDTH-1:0] in_lo_im,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_up_re,
  output logic signed [WIDTH-1:0] out_up_im,
  output logic signed [WIDTH-1:0] out_lo_re,
  output logic signed [WIDTH-1:0] out_lo_im,
  output logic                    ovf
);

  localparam int CW  = $clog2(2 * DELAY);
  localparam int EW  = 2 * WIDTH;          // one complex sample {im, re}
  localparam int LW  = DELAY * EW;         // one delay line
  localparam logic [CW-1:0] PRIME_AT = CW'(DELAY - 1);

  logic [CW-1:0]  r_cnt;
  logic           r_primed;
  logic [LW-1:0]  r_lo_dl;
  logic [LW-1:0]  r_up_dl;

  logic           w_adv;
  logic           w_sel;
  logic [EW-1:0]  w_x;
  logic [EW-1:0]  w_xl;
  logic [EW-1:0]  w_y;
  logic [EW-1:0]  w_u;
  logic [EW-1:0]  w_l;
  logic [EW-1:0]  w_ud;

  logic [WIDTH:0] w_s_re;
  logic [WIDTH:0] w_s_im;
  logic [WIDTH:0] w_d_re;
  logic [WIDTH:0] w_d_im;
  logic [WIDTH:0] w_sat_s_re;
  logic [WIDTH:0] w_sat_s_im;
  logic [WIDTH:0] w_sat_d_re;
  logic [WIDTH:0] w_sat_d_im;

  logic [WIDTH-1:0] w_nxt_up_re;
  logic [WIDTH-1:0] w_nxt_up_im;
  logic [WIDTH-1:0] w_nxt_lo_re;
  logic [WIDTH-1:0] w_nxt_lo_im;
  logic             w_nxt_ovf;

  function automatic logic [WIDTH:0] sext(input logic [WIDTH-1:0] v);
    return {v[WIDTH-1], v};
  endfunction

  // Returns {clipped, value}. Overflow at WIDTH+1 shows as the top two bits
  // disagreeing; the top bit then gives the direction of the clip.
  function automatic logic [WIDTH:0] sat(input logic [WIDTH:0] v);
    logic [WIDTH:0] r;
    if (v[WIDTH] == v[WIDTH-1])
      r = {1'b0, v[WIDTH-1:0]};
    else if (v[WIDTH])
      r = {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
    else
      r = {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
    return r;
  endfunction

  assign w_adv = in_valid | flush;
  // 2*DELAY is a power of two, so the counter wraps by itself and
  // (c >= DELAY) is just its top bit.
  assign w_sel = r_cnt[CW-1];

  assign w_x  = flush ? '0 : {in_up_im, in_up_re};
  assign w_xl = flush ? '0 : {in_lo_im, in_lo_re};

  // Delay lines shift in at the bottom; the oldest sample sits at the top.
  assign w_y  = r_lo_dl[LW-1 -: EW];
  assign w_u  = w_sel ? w_y : w_x;
  assign w_l  = w_sel ? w_x : w_y;
  assign w_ud = r_up_dl[LW-1 -: EW];

  assign w_s_re = sext(w_ud[WIDTH-1:0])  + sext(w_l[WIDTH-1:0]);
  assign w_s_im = sext(w_ud[EW-1:WIDTH]) + sext(w_l[EW-1:WIDTH]);
  assign w_d_re = sext(w_ud[WIDTH-1:0])  - sext(w_l[WIDTH-1:0]);
  assign w_d_im = sext(w_ud[EW-1:WIDTH]) - sext(w_l[EW-1:WIDTH]);

  assign w_sat_s_re = sat(w_s_re);
  assign w_sat_s_im = sat(w_s_im);
  assign w_sat_d_re = sat(w_d_re);
  assign w_sat_d_im = sat(w_d_im);

  always_comb begin
    w_nxt_up_re = w_ud[WIDTH-1:0];
    w_nxt_up_im = w_ud[EW-1:WIDTH];
    w_nxt_lo_re = w_l[WIDTH-1:0];
    w_nxt_lo_im = w_l[EW-1:WIDTH];
    w_nxt_ovf   = 1'b0;
    if (!bypass) begin
      if (SCALE != 0) begin
        w_nxt_up_re = w_s_re[WIDTH:1];
        w_nxt_up_im = w_s_im[WIDTH:1];
        w_nxt_lo_re = w_d_re[WIDTH:1];
        w_nxt_lo_im = w_d_im[WIDTH:1];
      end else begin
        w_nxt_up_re = w_sat_s_re[WIDTH-1:0];
        w_nxt_up_im = w_sat_s_im[WIDTH-1:0];
        w_nxt_lo_re = w_sat_d_re[WIDTH-1:0];
        w_nxt_lo_im = w_sat_d_im[WIDTH-1:0];
        w_nxt_ovf   = w_sat_s_re[WIDTH] | w_sat_s_im[WIDTH] |
                      w_sat_d_re[WIDTH] | w_sat_d_im[WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_primed  <= 1'b0;
      r_lo_dl   <= '0;
      r_up_dl   <= '0;
      out_valid <= 1'b0;
      out_up_re <= '0;
      out_up_im <= '0;
      out_lo_re <= '0;
      out_lo_im <= '0;
      ovf       <= 1'b0;
    end else begin
      // out_valid drops on any stall cycle; the data outputs keep their value.
      out_valid <= w_adv & r_primed;
      if (w_adv) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == PRIME_AT)
          r_primed <= 1'b1;
        r_lo_dl   <= (r_lo_dl << EW) | LW'(w_xl);
        r_up_dl   <= (r_up_dl << EW) | LW'(w_u);
        out_up_re <= w_nxt_up_re;
        out_up_im <= w_nxt_up_im;
        out_lo_re <= w_nxt_lo_re;
        out_lo_im <= w_nxt_lo_im;
        ovf       <= w_nxt_ovf;
      end
    end
  end

endmodule

// File: tb/tb_mdc_r2_stage.sv
// Directed bench for mdc_r2_stage. Four instances share one stimulus bus:
//   a: DELAY=1 SCALE=0   b: DELAY=1 SCALE=1   c: DELAY=4 SCALE=0   e: DELAY=2 SCALE=0
// Each step checks only the instance(s) that step is aimed at.
module tb_mdc_r2_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, flush, bypass;
  logic signed [8:0] up_re, up_im, lo_re, lo_im;

  logic ov_a, ovf_a, ov_b, ovf_b, ov_c, ovf_c, ov_e, ovf_e;
  logic signed [8:0] ur_a, ui_a, lr_a, li_a;
  logic signed [8:0] ur_b, ui_b, lr_b, li_b;
  logic signed [8:0] ur_c, ui_c, lr_c, li_c;
  logic signed [8:0] ur_e, ui_e, lr_e, li_e;

  int n_vec = 0;
  int n_err = 0;

  mdc_r2_stage #(.WIDTH(9), .DELAY(1), .SCALE(0)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .bypass(bypass),
    .in_up_re(up_re), .in_up_im(up_im), .in_lo_re(lo_re), .in_lo_im(lo_im),
    .out_valid(ov_a), .out_up_re(ur_a), .out_up_im(ui_a),
    .out_lo_re(lr_a), .out_lo_im(li_a), .ovf(ovf_a));

  mdc_r2_stage #(.WIDTH(9), .DELAY(1), .SCALE(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .bypass(bypass),
    .in_up_re(up_re), .in_up_im(up_im), .in_lo_re(lo_re), .in_lo_im(lo_im),
    .out_valid(ov_b), .out_up_re(ur_b), .out_up_im(ui_b),
    .out_lo_re(lr_b), .out_lo_im(li_b), .ovf(ovf_b));

  mdc_r2_stage #(.WIDTH(9), .DELAY(4), .SCALE(0)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .bypass(bypass),
    .in_up_re(up_re), .in_up_im(up_im), .in_lo_re(lo_re), .in_lo_im(lo_im),
    .out_valid(ov_c), .out_up_re(ur_c), .out_up_im(ui_c),
    .out_lo_re(lr_c), .out_lo_im(li_c), .ovf(ovf_c));

  mdc_r2_stage #(.WIDTH(9), .DELAY(2), .SCALE(0)) u_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .bypass(bypass),
    .in_up_re(up_re), .in_up_im(up_im), .in_lo_re(lo_re), .in_lo_im(lo_im),
    .out_valid(ov_e), .out_up_re(ur_e), .out_up_im(ui_e),
    .out_lo_re(lr_e), .out_lo_im(li_e), .ovf(ovf_e));

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic f, input int ur, input int ui,
                       input int lr, input int li);
    in_valid = v;
    flush    = f;
    up_re    = 9'(ur);
    up_im    = 9'(ui);
    lo_re    = 9'(lr);
    lo_im    = 9'(li);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // D=4 stream: valid outputs for advance indices 4..15
  // (upper pairs, lower pairs, then the zero tail of the flush).
  int exp4_ur[12] = '{4, 6, 8, 10, 204, 206, 208, 210, 0, 0, 0, 0};
  int exp4_lr[12] = '{-4, -4, -4, -4, -4, -4, -4, -4, 0, 0, 0, 0};

  initial begin
    int last_ur;
    int last_lr;

    rst = 1'b1;
    bypass = 1'b0;
    drive(1'b1, 1'b0, 50, 5, 60, 6);

    // Reset hold with in_valid asserted.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valid_a", ov_a, 0);
      chk("rst_up_a", ur_a, 0);
      chk("rst_lo_a", lr_a, 0);
      chk("rst_ovf_a", ovf_a, 0);
      chk("rst_valid_c", ov_c, 0);
      chk("rst_im_c", ui_c, 0);
    end
    rst = 1'b0;

    // D=1 basic butterfly, saturating (a) and scaling (b).
    drive(1'b1, 1'b0, 10, 0, 1, 0); tick();
    chk("d1_v0_a", ov_a, 0);
    chk("d1_v0_b", ov_b, 0);
    drive(1'b1, 1'b0, 3, 0, 2, 0); tick();
    chk("d1_v1_a", ov_a, 1);
    chk("d1_up1_a", ur_a, 13);
    chk("d1_lo1_a", lr_a, 7);
    chk("d1_im1_a", ui_a, 0);
    chk("d1_ovf1_a", ovf_a, 0);
    chk("d1_up1_b", ur_b, 6);
    chk("d1_lo1_b", lr_b, 3);
    chk("d1_v1_b", ov_b, 1);
    // Stall: valid drops, data holds, counter does not move.
    drive(1'b0, 1'b0, 99, 9, 99, 9); tick();
    chk("stall_v_a", ov_a, 0);
    chk("stall_up_a", ur_a, 13);
    chk("stall_lo_a", lr_a, 7);
    drive(1'b1, 1'b0, 0, 0, 0, 0); tick();
    chk("d1_v2_a", ov_a, 1);
    chk("d1_up2_a", ur_a, 3);
    chk("d1_lo2_a", lr_a, -1);
    chk("d1_up2_b", ur_b, 1);
    chk("d1_lo2_b", lr_b, -1);
    drive(1'b1, 1'b0, 0, 0, 0, 0); tick();
    chk("d1_v3_a", ov_a, 1);
    chk("d1_up3_a", ur_a, 0);
    chk("d1_lo3_a", lr_a, 0);

    // Saturation at WIDTH=9.
    rst = 1'b1; tick(); rst = 1'b0;
    drive(1'b1, 1'b0, 255, -256, 0, 0); tick();
    chk("sat_v0_a", ov_a, 0);
    drive(1'b1, 1'b0, 255, -256, 0, 0); tick();
    chk("sat_up_a", ur_a, 255);
    chk("sat_lo_a", lr_a, 0);
    chk("sat_upim_a", ui_a, -256);
    chk("sat_loim_a", li_a, 0);
    chk("sat_ovf_a", ovf_a, 1);
    chk("sat_up_b", ur_b, 255);
    chk("sat_upim_b", ui_b, -256);
    chk("sat_ovf_b", ovf_b, 0);
    drive(1'b1, 1'b0, -256, 0, 0, 0); tick();
    chk("sat_mid_up_a", ur_a, 0);
    chk("sat_mid_ovf_a", ovf_a, 0);
    drive(1'b1, 1'b0, 255, 0, 0, 0); tick();
    chk("satn_up_a", ur_a, -1);
    chk("satn_lo_a", lr_a, -256);
    chk("satn_ovf_a", ovf_a, 1);
    chk("satn_up_b", ur_b, -1);
    chk("satn_lo_b", lr_b, -256);
    chk("satn_ovf_b", ovf_b, 0);

    // Load junk into c mid-block, then reset with in_valid still high.
    drive(1'b1, 1'b0, 33, 3, 44, 4); tick();
    drive(1'b1, 1'b0, 33, 3, 44, 4); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mrst_v_c", ov_c, 0);
    chk("mrst_up_c", ur_c, 0);
    chk("mrst_loim_c", li_c, 0);

    // D=4 stream with stall gaps and a flush tail (garbage on ports during flush).
    last_ur = 0;
    last_lr = 0;
    for (int idx = 0; idx < 16; idx++) begin
      if (idx % 3 == 1) begin
        drive(1'b0, 1'b0, 77, 77, 77, 77); tick();
        chk("d4_gap_v", ov_c, 0);
        chk("d4_gap_up", ur_c, last_ur);
        chk("d4_gap_lo", lr_c, last_lr);
      end
      if (idx < 8)
        drive(1'b1, 1'b0, idx, -idx, 100 + idx, -(100 + idx));
      else
        drive(idx == 10, 1'b1, 123, 123, 123, 123);
      tick();
      if (idx < 4) begin
        chk("d4_unprimed_v", ov_c, 0);
      end else begin
        last_ur = exp4_ur[idx-4];
        last_lr = exp4_lr[idx-4];
        chk("d4_v", ov_c, 1);
        chk("d4_up_re", ur_c, last_ur);
        chk("d4_lo_re", lr_c, last_lr);
        chk("d4_up_im", ui_c, -last_ur);
        chk("d4_lo_im", li_c, -last_lr);
        chk("d4_ovf", ovf_c, 0);
      end
    end

    // Bypass on D=2: sums that would clip must pass through raw, ovf stays 0.
    rst = 1'b1; tick(); rst = 1'b0;
    bypass = 1'b1;
    drive(1'b1, 1'b0, 200, 0, 1, 0); tick();
    chk("byp_v0_e", ov_e, 0);
    drive(1'b1, 1'b0, 210, 0, 2, 0); tick();
    chk("byp_v1_e", ov_e, 0);
    drive(1'b1, 1'b0, 220, 0, 3, 0); tick();
    chk("byp_v2_e", ov_e, 1);
    chk("byp_up2_e", ur_e, 200);
    chk("byp_lo2_e", lr_e, 220);
    chk("byp_ovf2_e", ovf_e, 0);
    drive(1'b1, 1'b0, 230, 0, 4, 0); tick();
    chk("byp_up3_e", ur_e, 210);
    chk("byp_lo3_e", lr_e, 230);
    chk("byp_ovf3_e", ovf_e, 0);
    drive(1'b1, 1'b0, 240, 0, 5, 0); tick();
    chk("byp_up4_e", ur_e, 1);
    chk("byp_lo4_e", lr_e, 3);
    drive(1'b1, 1'b0, 250, 0, 6, 0); tick();
    chk("byp_up5_e", ur_e, 2);
    chk("byp_lo5_e", lr_e, 4);
    bypass = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
